// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the flash program loader.
package program_loader_pkg;
    localparam int FLASH_DEPTH = 1024;
    localparam int WORD_W      = 16;
    localparam int FLASH_AW    = $clog2(FLASH_DEPTH);

    // Prefixed so they never collide with the pipeline's S1..S3 states.
    typedef enum logic [2:0] {
        L_IDLE,
        L_LEN,
        L_DATA,
        L_CSUM,
        L_DONE,
        L_ERR
    } loader_state_t;

    // States in which the loader consumes stream words.
    function automatic logic accepts_words(loader_state_t s);
        return (s == L_LEN) || (s == L_DATA) || (s == L_CSUM);
    endfunction
endpackage

// File: rtl/program_loader_if.sv
// Word-stream input and flash write port of the program loader.
interface program_loader_if
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = FLASH_AW,
    parameter int DATA_W = WORD_W
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // Stream source / flash observer side.
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    // Loader side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/program_loader_checksum.sv
// 16-bit wraparound accumulator of payload words, with clear and enable.
module loader_checksum
    import program_loader_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] word,
    output logic [W-1:0] sum
);
    // Clear wins over accumulate; overflow simply wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   sum <= '0;
        else if (clr) sum <= '0;
        else if (en)  sum <= sum + word;
    end
endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed, checksummed image into instruction flash and
// keeps the core stalled until the whole image is in and verified.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DEPTH  = FLASH_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    program_loader_if.slave   bus,
    output logic              cpu_run,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);
    localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);

    loader_state_t     state, state_nx;
    logic              xfer;
    logic              clr_load;
    logic              take_len;
    logic              take_word;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] sum;

    assign xfer         = bus.in_valid && bus.in_ready;
    assign words_loaded = count;

    loader_checksum #(.W(DATA_W)) u_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_load),
        .en    (take_word),
        .word  (bus.in_data),
        .sum   (sum)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= L_IDLE;
        else        state <= state_nx;
    end

    // Next state plus the single-cycle control strobes for the datapath.
    always_comb begin
        state_nx  = state;
        clr_load  = 1'b0;
        take_len  = 1'b0;
        take_word = 1'b0;
        case (state)
            L_IDLE, L_DONE, L_ERR: begin
                if (start) begin
                    state_nx = L_LEN;
                    clr_load = 1'b1;
                end
            end
            L_LEN: begin
                if (xfer) begin
                    take_len = 1'b1;
                    if (bus.in_data > DEPTH_W)  state_nx = L_ERR;
                    else if (bus.in_data == '0) state_nx = L_CSUM;
                    else                        state_nx = L_DATA;
                end
            end
            L_DATA: begin
                if (xfer) begin
                    take_word = 1'b1;
                    if ((count + 1'b1) == len) state_nx = L_CSUM;
                end
            end
            L_CSUM: begin
                if (xfer) state_nx = (bus.in_data == sum) ? L_DONE : L_ERR;
            end
            default: state_nx = L_IDLE;
        endcase
    end

    // Status outputs are registered decodes of the state being entered, so
    // they line up with the state register and never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.in_ready <= 1'b0;
            done         <= 1'b0;
            cpu_run      <= 1'b0;
            error        <= 1'b0;
        end else begin
            bus.in_ready <= accepts_words(state_nx);
            done         <= (state_nx == L_DONE);
            cpu_run      <= (state_nx == L_DONE);
            error        <= (state_nx == L_ERR);
        end
    end

    // Length latch, payload counter and the one-cycle-delayed flash write.
    // Only the low ADDR_W+1 bits of the length are kept; anything larger
    // has already been routed to ERR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len           <= '0;
            count         <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= take_word;
            if (clr_load) count <= '0;
            if (take_len) len   <= bus.in_data[ADDR_W:0];
            if (take_word) begin
                bus.mem_addr  <= count[ADDR_W-1:0];
                bus.mem_wdata <= bus.in_data;
                count         <= count + 1'b1;
            end
        end
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Loads a PDP-11 program image from a 16-bit word stream into the 1024x16 instruction flash.
- Holds the CPU core stalled until the image is fully written and its checksum has passed.
- It is the write side of the flash fetch path: the core's fetch stage and the simulation monitor read what this block writes.
- Sits between the bench or host stream source and the flash write port; its cpu_run output gates the pipeline state machine.

Parameters:
- DEPTH, 1024, flash words.
- ADDR_W, 10, flash address width; equals clog2(DEPTH).
- DATA_W, 16, word width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  in  1  stream word valid.
- in_data  in  DATA_W  stream word.
- in_ready  out  1  block accepts a word this cycle.
- mem_we  out  1  flash write strobe.
- mem_addr  out  ADDR_W  flash write address.
- mem_wdata  out  DATA_W  flash write data.
- cpu_run  out  1  high releases the core; low stalls it.
- done  out  1  load complete with a good checksum.
- error  out  1  load aborted: bad length or bad checksum.
- words_loaded  out  ADDR_W+1  payload words written so far.

Behaviour:
- Reset (async, any state, including mid-load):
  - state=IDLE.
  - All outputs 0: in_ready, mem_we, mem_addr, mem_wdata, cpu_run, done, error, words_loaded.
  - Internal sum and count cleared.
- Transfer rule: a word transfers on a rising clk edge with in_valid&&in_ready. in_ready is a registered function of state only.
  - in_ready=1 in LEN, DATA and CSUM.
  - in_ready=0 in IDLE, DONE and ERR.
- Stream format: length word N, then N payload words, then a checksum word. The checksum is the 16-bit wraparound sum of the payload words.
- FSM states: IDLE, LEN, DATA, CSUM, DONE, ERR.
  - IDLE: start -> LEN. Clears sum, count, done and error; cpu_run=0.
  - LEN: on transfer, latch N.
    - N>DEPTH -> ERR.
    - N==0 -> CSUM.
    - Otherwise -> DATA.
  - DATA: on transfer of word k (0-based):
    - Next cycle: mem_we=1, mem_addr=k, mem_wdata=word. Write latency is 1 cycle; mem_we is a single-cycle pulse per accepted word.
    - sum += word mod 2^16; words_loaded = k+1.
    - After word N-1 -> CSUM.
  - CSUM: on transfer, if word == sum -> DONE, else -> ERR.
  - DONE: done=1, cpu_run=1, held until reset or start. start -> LEN, dropping cpu_run and done the next cycle.
  - ERR: error=1, cpu_run=0, held until reset or start. start -> LEN.
- Gaps: in_valid low for any number of cycles stalls the FSM with no state change and no write.
- start in LEN, DATA or CSUM is ignored; a load cannot be restarted except via reset.
- start and a transfer in the same cycle in DONE or ERR: start wins. The word is not accepted because in_ready=0.
- mem_addr wraps nowhere: N<=DEPTH guarantees the top address is DEPTH-1. N==DEPTH is legal.
- No flash reads are performed. Locations past N keep their previous contents.

Decomposition:
- Shared parameters package holds:
  - loader_state_t enum {L_IDLE, L_LEN, L_DATA, L_CSUM, L_DONE, L_ERR}, prefixed to avoid a clash with the pipeline's S1..S3.
  - FLASH_DEPTH and WORD_W constants.
- One natural sub-module: loader_checksum, the 16-bit accumulator with clear and enable inputs.
- Everything else stays in a single FSM module.

Test Plan:
- Normal load:
  - Stimulus: start, then stream 3, 0o012700, 0o000005, 0o000777, checksum 0o013704.
  - Required: three mem_we pulses at addr 0,1,2 each one cycle after acceptance; done=1, cpu_run=1, words_loaded=3, error=0.
- Bad checksum: same stream with checksum 0o013705 -> error=1, done=0, cpu_run=0, words_loaded=3.
- Length bounds:
  - N=1025 -> ERR right after the length word, no mem_we.
  - N=0 with checksum 0 -> DONE with no writes.
  - N=1024 with all words 0xFFFF and checksum 0xFC00 -> DONE, last write at addr 1023.
- Backpressure and gaps: random in_valid low gaps during a 5-word load -> write order and addresses identical to the gap-free run; no write in gap cycles.
- Reset and restart:
  - Assert rst_n low after 2 of 4 payload words -> all outputs 0 immediately (asynchronously).
  - A fresh start and full load then completes with DONE.
  - start pulsed while in DATA is ignored.
- Reload from DONE: start in DONE -> cpu_run falls the next cycle; a second image loads and DONE reasserts.
